uart_mmio_responder: RTL
========================

# uart_mmio_responder

Memory-mapped responder on the CPU side of the UART address window. It decodes the load and store strobes that the address decoder raises for UART space, and provides three things: a status register, a transmit holding register, and a receive buffer. It sits between the CPU datapath's memory stage and the UART transmitter/receiver pair, and converts single-cycle CPU accesses into ready/valid handshakes with the serial logic.

## Interface
- RX_DEPTH, 4, receive buffer depth in bytes; power of two, ≥2; used only when UART_RX_FIFO_EN is defined
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- WEUART  in  1  store strobe, one cycle per CPU store to UART space
- REUART  in  1  load strobe, one cycle per CPU load from UART space
- RegSel  in  2  Address[3:2]: 00 status, 01 RX data, 10 TX data, 11 reserved
- WriteData  in  8  store data, low byte
- ReadData  out  32  load result, registered
- DataIn  out  8  byte to transmitter
- DataInValid  out  1  TX byte offered
- DataInReady  in  1  transmitter accepts
- DataOut  in  8  byte from receiver
- DataOutValid  in  1  receiver offers byte
- DataOutReady  out  1  responder accepts

## Operation
- Status word: bit0 tx_ready (TX holding empty), bit1 rx_valid (≥1 byte buffered), bit2 tx_drop (sticky), bits 31:3 zero.
- TX store (WEUART, RegSel=10) with holding empty: latch WriteData into DataIn and set DataInValid.
- TX store with holding full: byte discarded and tx_drop set. DataIn and DataInValid unchanged.
- DataInValid clears on the edge where DataInValid&&DataInReady. A store in that same cycle is accepted (holding reloads, DataInValid stays 1).
- DataIn must stay stable while DataInValid=1.
- RX push: DataOutValid&&DataOutReady captures DataOut at the tail. DataOutReady = buffer not full, combinational from registered count.
- RX load (REUART, RegSel=01) with buffer non-empty: ReadData ← {24'b0, head}, and the head is popped.
- RX load with buffer empty: ReadData ← 0, no pop, no error.
- Push and pop in the same cycle: both performed; count unchanged; a pop from a 1-entry buffer returns the old head.
- Status load: ReadData ← status word. A status load clears tx_drop on the same edge. If a TX drop occurs in that same cycle, the returned value shows the old tx_drop and the bit is then set.
- RegSel=10 load and RegSel=11 load: ReadData ← 0.
- RegSel≠10 store: ignored.
- WEUART and REUART in the same cycle: both processed independently.
- ReadData holds its value when REUART=0.
- Count width: clog2(RX_DEPTH)+1. Pointers wrap modulo RX_DEPTH.

## Timing
- Reset values: ReadData=0, DataIn=0, DataInValid=0, tx_drop=0, RX count=0, DataOutReady=1.
- Load latency: 1 cycle; ReadData is valid the cycle after REUART.
- Store to DataInValid high: 1 cycle.
- Push to rx_valid visible in status: 1 cycle.
- Reset mid-transfer: buffered RX bytes and any pending TX byte are lost. DataInValid drops asynchronously.

## Configuration
- UART_RX_FIFO_EN defined: RX buffer is a circular FIFO of RX_DEPTH bytes, and DataOutReady stays high until RX_DEPTH bytes are held.
- UART_RX_FIFO_EN undefined: single-byte holding register (depth 1) and RX_DEPTH is ignored.
  - DataOutReady falls the cycle after a capture.
  - DataOutReady returns high the cycle after the popping load.
  - A push in the same cycle as a pop is impossible because ready is 0 while full.

## Test plan
- Reset, then status load → ReadData=0x00000001; DataOutReady=1, DataInValid=0.
- Store 0x41 to TX with DataInReady held 0 for 5 cycles, then 1 → DataIn=0x41 and DataInValid=1 from cycle+1 through the accept edge, then 0; status bit0 tracks it.
- Store 0x41, then 0x42 while busy → 0x42 never appears on DataIn; status load returns 0x5 after accept; the next status load returns 0x1.
- Receiver pushes 0x10, 0x20, 0x30 → three RX loads return 0x10, 0x20, 0x30; a fourth returns 0; status bit1 clears after the third.
- FIFO build: push 4 bytes with no loads → DataOutReady=0 after the 4th; one RX load re-raises it; simultaneous push+pop keeps count. Non-FIFO build: ready falls after 1 byte.
- Assert rst asynchronously while DataInValid=1 and 2 RX bytes are held → all outputs return to reset values before the next clk edge; a subsequent RX load returns 0.

Source files
------------

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: CPU-side responder for the UART address window.
// Exposes a status word, a TX holding register (ready/valid toward the
// transmitter) and an RX buffer (ready/valid from the receiver).
// Build macro UART_RX_FIFO_EN: when defined the RX buffer is an RX_DEPTH-byte
// circular FIFO; when undefined it is a single-byte holding register.
module uart_mmio_responder #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WEUART,
  input  logic        REUART,
  input  logic [1:0]  RegSel,
  input  logic [7:0]  WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam logic [1:0] SEL_STATUS = 2'b00;
  localparam logic [1:0] SEL_RX     = 2'b01;
  localparam logic [1:0] SEL_TX     = 2'b10;

  logic        tx_store, tx_free, tx_accept, tx_drop_now, tx_drop;
  logic        status_load, rx_load, rx_push, rx_pop, rx_nonempty;
  logic [7:0]  rx_head;
  logic [31:0] status_word, read_mux;

  // A store is taken whenever the holding register is empty or being drained
  // on this very edge; otherwise the byte is lost and flagged.
  assign tx_store    = WEUART && (RegSel == SEL_TX);
  assign tx_free     = !DataInValid || DataInReady;
  assign tx_accept   = tx_store && tx_free;
  assign tx_drop_now = tx_store && !tx_free;

  assign status_load = REUART && (RegSel == SEL_STATUS);
  assign rx_load     = REUART && (RegSel == SEL_RX);
  assign rx_push     = DataOutValid && DataOutReady;
  assign rx_pop      = rx_load && rx_nonempty;

`ifdef UART_RX_FIFO_EN
  localparam int             AW      = $clog2(RX_DEPTH);
  localparam logic [AW:0]    FULL    = (AW+1)'(RX_DEPTH);
  localparam logic [AW:0]    CNT_ONE = 1;
  localparam logic [AW-1:0]  PTR_ONE = 1;

  logic [AW:0]   rx_count;
  logic [AW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [7:0]    rx_mem [RX_DEPTH];

  assign rx_nonempty  = (rx_count != '0);
  assign rx_head      = rx_mem[rx_rd_ptr];
  assign DataOutReady = (rx_count != FULL);

  // FIFO pointers (wrap naturally, depth is a power of two) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count  <= '0;
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // FIFO storage: data only, contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= DataOut;
  end
`else
  logic       rx_full;
  logic [7:0] rx_byte;

  assign rx_nonempty  = rx_full;
  assign rx_head      = rx_byte;
  assign DataOutReady = !rx_full;

  // Single-entry occupancy; push and pop never coincide since ready is low when full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full <= 1'b0;
    end else if (rx_push) begin
      rx_full <= 1'b1;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // Single-entry storage: data only
  always_ff @(posedge clk) begin
    if (rx_push) rx_byte <= DataOut;
  end
`endif

  // TX holding register and sticky drop flag (a drop beats a clearing status load)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DataIn      <= '0;
      DataInValid <= 1'b0;
      tx_drop     <= 1'b0;
    end else begin
      if (tx_accept) begin
        DataIn      <= WriteData;
        DataInValid <= 1'b1;
      end else if (DataInReady) begin
        DataInValid <= 1'b0;
      end
      if (tx_drop_now) begin
        tx_drop <= 1'b1;
      end else if (status_load) begin
        tx_drop <= 1'b0;
      end
    end
  end

  // Load data selection from pre-edge register state
  always_comb begin
    status_word = {29'd0, tx_drop, rx_nonempty, !DataInValid};
    read_mux    = '0;
    case (RegSel)
      SEL_STATUS: read_mux = status_word;
      SEL_RX:     read_mux = rx_nonempty ? {24'd0, rx_head} : 32'd0;
      default:    read_mux = '0;
    endcase
  end

  // Registered load result, held between loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData <= '0;
    end else if (REUART) begin
      ReadData <= read_mux;
    end
  end

endmodule
